// File: rtl/alu_div_iter.sv
// Iterative restoring divider/remainder unit for EX: one operation in flight, valid/ready on both
// sides. The ALU_DIV_EARLY_EXIT_EN macro adds a 1-cycle path for |a| < |b|.
module alu_div_iter #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned UNROLL = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int unsigned ITER = XLEN / UNROLL;
  localparam int unsigned CW   = $clog2(ITER + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic            is_rem_q, is_rem_d;
  logic            quo_neg_q, quo_neg_d;
  logic            rem_neg_q, rem_neg_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvsr_q, dvsr_d;
  logic [XLEN-1:0] result_q, result_d;

  // Operand decode at accept; op[0] marks unsigned, op[1] marks remainder.
  logic            is_signed, a_neg, b_neg, b_zero, ovf;
  logic [XLEN-1:0] abs_a, abs_b;

  assign is_signed = ~op[0];
  assign a_neg     = is_signed & a[XLEN-1];
  assign b_neg     = is_signed & b[XLEN-1];
  assign abs_a     = a_neg ? (XLEN'(0) - a) : a;
  assign abs_b     = b_neg ? (XLEN'(0) - b) : b;
  assign b_zero    = (b == '0);
  assign ovf       = is_signed & (a == {1'b1, {(XLEN-1){1'b0}}}) & (b == '1);

  // UNROLL restoring steps per cycle; the shifted partial remainder needs one extra bit.
  logic [XLEN-1:0] step_rem, step_quo;
  logic [XLEN:0]   shifted, trial;

  always_comb begin
    step_rem = rem_q;
    step_quo = quo_q;
    shifted  = '0;
    trial    = '0;
    for (int unsigned i = 0; i < UNROLL; i++) begin
      shifted  = {step_rem, step_quo[XLEN-1]};
      trial    = shifted - {1'b0, dvsr_q};
      step_quo = {step_quo[XLEN-2:0], ~trial[XLEN]};
      step_rem = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
    end
  end

  logic [XLEN-1:0] quo_fix, rem_fix, calc_res;

  assign quo_fix  = quo_neg_q ? (XLEN'(0) - step_quo) : step_quo;
  assign rem_fix  = rem_neg_q ? (XLEN'(0) - step_rem) : step_rem;
  assign calc_res = is_rem_q ? rem_fix : quo_fix;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    is_rem_d  = is_rem_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    result_d  = result_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          is_rem_d  = op[1];
          quo_neg_d = ~op[1] & (a_neg ^ b_neg);
          rem_neg_d = op[1] & a_neg;
          if (b_zero) begin
            state_d  = StDone;
            result_d = op[1] ? a : '1;
          end else if (ovf) begin
            state_d  = StDone;
            result_d = op[1] ? '0 : a;
`ifdef ALU_DIV_EARLY_EXIT_EN
          end else if (abs_a < abs_b) begin
            state_d  = StDone;
            result_d = op[1] ? a : '0;
`endif
          end else begin
            state_d = StCalc;
            count_d = '0;
            rem_d   = '0;
            quo_d   = abs_a;
            dvsr_d  = abs_b;
          end
        end
      end
      StCalc: begin
        rem_d   = step_rem;
        quo_d   = step_quo;
        count_d = count_q + CW'(1);
        if (count_q == CW'(ITER - 1)) begin
          state_d  = StDone;
          result_d = calc_res;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Flush beats both handshakes and must not disturb the held result.
    if (flush) begin
      state_d  = StIdle;
      count_d  = '0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      count_q   <= '0;
      is_rem_q  <= 1'b0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      is_rem_q  <= is_rem_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      result_q  <= result_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign result    = result_q;

endmodule

// File: tb/tb_alu_div_iter.sv
// Directed bench for alu_div_iter: a 64-bit radix-2 instance and a 32-bit UNROLL=4 instance
// sharing reset, flush, operands and out_ready.
module tb_alu_div_iter;

`ifdef ALU_DIV_EARLY_EXIT_EN
  localparam int EeLat0 = 1;
  localparam int EeLat1 = 1;
`else
  localparam int EeLat0 = 65;
  localparam int EeLat1 = 9;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic [1:0]  op = '0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        out_ready = 1'b1;
  logic        iv0 = 1'b0, iv1 = 1'b0;
  logic        ir0, ir1, ov0, ov1, busy0, busy1;
  logic [63:0] res0;
  logic [31:0] res1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_div_iter #(.XLEN(64), .UNROLL(1)) u_div64 (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (iv0),
    .in_ready (ir0),
    .op       (op),
    .a        (a),
    .b        (b),
    .out_valid(ov0),
    .out_ready(out_ready),
    .result   (res0),
    .busy     (busy0)
  );

  alu_div_iter #(.XLEN(32), .UNROLL(4)) u_div32 (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (iv1),
    .in_ready (ir1),
    .op       (op),
    .a        (a[31:0]),
    .b        (b[31:0]),
    .out_valid(ov1),
    .out_ready(out_ready),
    .result   (res1),
    .busy     (busy1)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  // Issue one op on instance sel, then check latency, result and return to idle.
  // hold > 0 keeps out_ready low for that many cycles in DONE.
  task automatic run_op(input string tag, input bit sel, input logic [1:0] o,
                        input logic [63:0] aa, input logic [63:0] bb,
                        input logic [63:0] exp, input int exp_lat, input int hold);
    int lat;
    @(negedge clk);
    op = o;
    a  = aa;
    b  = bb;
    out_ready = (hold == 0);
    if (sel) iv1 = 1'b1;
    else     iv0 = 1'b1;
    check_eq({tag, " in_ready"}, 64'(sel ? ir1 : ir0), 64'd1);
    @(posedge clk);
    #1;
    iv0 = 1'b0;
    iv1 = 1'b0;
    op  = ~o;
    a   = ~aa;
    b   = ~bb;
    lat = 1;
    while (!(sel ? ov1 : ov0) && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check_eq({tag, " result"}, sel ? {32'd0, res1} : res0, exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check_eq({tag, " held result"}, sel ? {32'd0, res1} : res0, exp);
      check_eq({tag, " held in_ready"}, 64'(sel ? ir1 : ir0), 64'd0);
      check_eq({tag, " held busy"}, 64'(sel ? busy1 : busy0), 64'd1);
      check_eq({tag, " held out_valid"}, 64'(sel ? ov1 : ov0), 64'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq({tag, " idle out_valid"}, 64'(sel ? ov1 : ov0), 64'd0);
    check_eq({tag, " idle in_ready"}, 64'(sel ? ir1 : ir0), 64'd1);
  endtask

  initial begin
    bit seen;
    #2;
    check_eq("reset out_valid", 64'(ov0), 64'd0);
    check_eq("reset busy", 64'(busy0), 64'd0);
    check_eq("reset result", res0, 64'd0);
    check_eq("reset in_ready", 64'(ir0), 64'd1);
    @(negedge clk);
    reset = 1'b0;

    // 64-bit, UNROLL=1
    run_op("div 100/7", 0, 2'b00, 64'd100, 64'd7, 64'd14, 65, 0);
    run_op("rem 100/7", 0, 2'b10, 64'd100, 64'd7, 64'd2, 65, 0);
    run_op("div -7/2", 0, 2'b00, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
           64'hFFFF_FFFF_FFFF_FFFD, 65, 0);
    run_op("rem -7/2", 0, 2'b10, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
           64'hFFFF_FFFF_FFFF_FFFF, 65, 0);
    run_op("divu max/2", 0, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,
           64'h7FFF_FFFF_FFFF_FFFF, 65, 0);
    run_op("div 5/0", 0, 2'b00, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
    run_op("remu 5/0", 0, 2'b11, 64'd5, 64'd0, 64'd5, 1, 0);
    run_op("div ovf", 0, 2'b00, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h8000_0000_0000_0000, 1, 0);
    run_op("rem ovf", 0, 2'b10, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'd0, 1, 0);
    run_op("remu 3/10", 0, 2'b11, 64'd3, 64'd10, 64'd3, EeLat0, 0);
    run_op("backpressure", 0, 2'b00, 64'd100, 64'd7, 64'd14, 65, 5);

    // Flush at CALC cycle 10: no result, then a fresh op completes normally.
    @(negedge clk);
    op  = 2'b00;
    a   = 64'd100;
    b   = 64'd7;
    iv0 = 1'b1;
    @(posedge clk);
    #1;
    iv0 = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check_eq("flush in_ready", 64'(ir0), 64'd1);
    check_eq("flush busy", 64'(busy0), 64'd0);
    seen = 1'b0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (ov0) seen = 1'b1;
    end
    check_eq("flush no out_valid", 64'(seen), 64'd0);
    run_op("div 9/3", 0, 2'b00, 64'd9, 64'd3, 64'd3, 65, 0);

    // Reset mid-CALC clears outputs without waiting for a clock edge.
    @(negedge clk);
    op  = 2'b00;
    a   = 64'd1000;
    b   = 64'd3;
    iv0 = 1'b1;
    @(posedge clk);
    #1;
    iv0 = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check_eq("pre-reset busy", 64'(busy0), 64'd1);
    reset = 1'b1;
    #1;
    check_eq("async reset out_valid", 64'(ov0), 64'd0);
    check_eq("async reset busy", 64'(busy0), 64'd0);
    check_eq("async reset in_ready", 64'(ir0), 64'd1);
    check_eq("async reset result", res0, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // 32-bit, UNROLL=4
    run_op("u4 div -100/7", 1, 2'b00, 64'hFFFF_FF9C, 64'd7, 64'hFFFF_FFF2, 9, 0);
    run_op("u4 rem -100/7", 1, 2'b10, 64'hFFFF_FF9C, 64'd7, 64'hFFFF_FFFE, 9, 0);
    run_op("u4 div 100/-7", 1, 2'b00, 64'd100, 64'hFFFF_FFF9, 64'hFFFF_FFF2, 9, 0);
    run_op("u4 rem 100/-7", 1, 2'b10, 64'd100, 64'hFFFF_FFF9, 64'd2, 9, 0);
    run_op("u4 divu max/16", 1, 2'b01, 64'hFFFF_FFFF, 64'd16, 64'h0FFF_FFFF, 9, 0);
    run_op("u4 remu max/16", 1, 2'b11, 64'hFFFF_FFFF, 64'd16, 64'hF, 9, 0);
    run_op("u4 divu 1e6/1e3", 1, 2'b01, 64'd1000000, 64'd1000, 64'd1000, 9, 0);
    run_op("u4 div ovf", 1, 2'b00, 64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000, 1, 0);
    run_op("u4 remu 7/0", 1, 2'b11, 64'd7, 64'd0, 64'd7, 1, 0);
    run_op("u4 div -3/5", 1, 2'b00, 64'hFFFF_FFFD, 64'd5, 64'd0, EeLat1, 0);
    run_op("u4 rem -3/5", 1, 2'b10, 64'hFFFF_FFFD, 64'd5, 64'hFFFF_FFFD, EeLat1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
